// File: rtl/fpu_ss_pkg.sv
// Shared types and helpers for the FPU subsystem core-sharing logic.
package fpu_ss_pkg;

    // Widest core-ID vector the one-hot helper accepts. Narrower vectors are zero-extended.
    localparam int unsigned MAX_CORES = 32;

    // States of the issue arbiter: no grant held, or grant held until the handshake completes.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // True when exactly one bit of vec is set.
    function automatic logic onehot_valid(input logic [MAX_CORES-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_CORES'(1))) == '0);
    endfunction

endpackage

// File: rtl/fpu_ss_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at an index >= start_i, wrapping past N-1 to 0.
module fpu_ss_rr_pick #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotate the requests so start_i lands on bit 0. Take the lowest set bit, then undo the rotation.
    always_comb begin
        dbl     = {req_i, req_i} >> start_i;
        rot     = dbl[N-1:0];
        found_o = 1'b0;
        off     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found_o = 1'b1;
                off     = IW'(k);
            end
        end
        sum = {1'b0, start_i} + {1'b0, off};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx_o = sum[IW-1:0];
    end

endmodule

// File: rtl/fpu_ss_core_arbiter.sv
// Shares one FPU subsystem issue/result port pair between NB_CORES cores.
// Issue arbitration is round-robin. A grant stays locked until its handshake completes.
// Each result is routed back to its core using the one-hot core ID.
// Per-core counters limit how many instructions each core has in flight.
module fpu_ss_core_arbiter #(
    parameter int unsigned NB_CORES        = 8,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NB_CORES-1:0]            core_issue_valid_i,
    output logic [NB_CORES-1:0]            core_issue_ready_o,
    input  logic [NB_CORES*DATA_WIDTH-1:0] core_issue_data_i,
    output logic                           fpu_issue_valid_o,
    input  logic                           fpu_issue_ready_i,
    output logic [DATA_WIDTH-1:0]          fpu_issue_data_o,
    output logic [NB_CORES-1:0]            fpu_issue_core_id_o,
    input  logic                           fpu_result_valid_i,
    output logic                           fpu_result_ready_o,
    input  logic [NB_CORES-1:0]            fpu_result_core_id_i,
    output logic [NB_CORES-1:0]            core_result_valid_o,
    input  logic [NB_CORES-1:0]            core_result_ready_i,
    output logic                           busy_o,
    output logic                           err_o
);

    import fpu_ss_pkg::*;

    localparam int unsigned IW = $clog2(NB_CORES);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e         state_q;
    logic [IW-1:0]      rr_q, gnt_q;
    logic [CW-1:0]      cnt_q [NB_CORES];
    logic [CW-1:0]      cnt_d [NB_CORES];
    logic               err_q, err_d;

    logic [NB_CORES-1:0] eligible;
    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic                gnt_valid;
    logic [IW-1:0]       gnt;
    logic [IW-1:0]       rr_next;
    logic                issue_hs;
    logic                res_onehot;
    logic                res_hs;
    logic [IW-1:0]       res_dest;
    logic [NB_CORES-1:0] inc_vec, dec_vec;

    // A core may compete only while it is requesting and still has issue credit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            eligible[i] = core_issue_valid_i[i] && (cnt_q[i] < CW'(MAX_OUTSTANDING));
        end
    end

    fpu_ss_rr_pick #(
        .N  (NB_CORES),
        .IW (IW)
    ) u_rr_pick (
        .req_i   (eligible),
        .start_i (rr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // A locked grant overrides the picker, so the payload stays stable while the FPU stalls.
    always_comb begin
        gnt_valid = pick_found;
        gnt       = pick_idx;
        if (state_q == LOCKED) begin
            gnt_valid = 1'b1;
            gnt       = gnt_q;
        end
        rr_next = (gnt == IW'(NB_CORES - 1)) ? '0 : gnt + IW'(1);
    end

    // Issue mux: forward the granted core's request and return the FPU ready to that core only.
    always_comb begin
        fpu_issue_valid_o   = gnt_valid & core_issue_valid_i[gnt];
        fpu_issue_data_o    = '0;
        fpu_issue_core_id_o = '0;
        core_issue_ready_o  = '0;
        if (gnt_valid) begin
            fpu_issue_data_o         = core_issue_data_i[gnt*DATA_WIDTH +: DATA_WIDTH];
            fpu_issue_core_id_o[gnt] = 1'b1;
            core_issue_ready_o[gnt]  = fpu_issue_ready_i;
        end
        issue_hs = fpu_issue_valid_o & fpu_issue_ready_i;
    end

    // Result routing. A malformed ID is accepted and dropped, so it cannot stall the FPU.
    always_comb begin
        res_onehot = onehot_valid(MAX_CORES'(fpu_result_core_id_i));
        res_dest   = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            if (fpu_result_core_id_i[i]) begin
                res_dest = IW'(i);
            end
        end
        core_result_valid_o = (fpu_result_valid_i && res_onehot) ? fpu_result_core_id_i : '0;
        fpu_result_ready_o  = (fpu_result_valid_i & ~res_onehot)
                            | (|(core_result_ready_i & fpu_result_core_id_i));
        res_hs = fpu_result_valid_i & res_onehot
               & (|(core_result_ready_i & fpu_result_core_id_i));
    end

    // Credit bookkeeping.
    // An issue and a result on the same core cancel out.
    // A decrement at zero is dropped and flagged as an error.
    always_comb begin
        err_d   = fpu_result_valid_i & ~res_onehot;
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NB_CORES; i++) begin
            inc_vec[i] = issue_hs && (gnt == IW'(i));
            dec_vec[i] = res_hs && (res_dest == IW'(i));
            cnt_d[i]   = cnt_q[i];
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end
        end
    end

    // Busy while any core has an instruction in flight.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NB_CORES; i++) begin
            busy_o = busy_o | (cnt_q[i] != '0);
        end
    end

    assign err_o = err_q;

    // Arbitration FSM.
    // Lock a grant that is not accepted at once.
    // Advance the round-robin pointer past the core that completes a handshake.
    // If the locked core drops its request, unlock without advancing the pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_hs) begin
                        rr_q <= rr_next;
                    end else if (pick_found) begin
                        state_q <= LOCKED;
                        gnt_q   <= pick_idx;
                    end
                end
                LOCKED: begin
                    if (issue_hs) begin
                        state_q <= IDLE;
                        rr_q    <= rr_next;
                    end else if (!core_issue_valid_i[gnt_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Register the per-core counters and the one-cycle error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
            for (int i = 0; i < NB_CORES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 0; i < NB_CORES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fpu_ss_core_arbiter.sv
// Self-checking bench for fpu_ss_core_arbiter.
// Directed scenarios with literal expectations, then randomized traffic checked against a behavioural model.
module tb_fpu_ss_core_arbiter;

    localparam int NB   = 8;
    localparam int DW   = 64;
    localparam int MAXO = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NB-1:0]     civ;
    logic [NB-1:0]     cir;
    logic [NB*DW-1:0]  cid;
    logic              fiv;
    logic              fir;
    logic [DW-1:0]     fid;
    logic [NB-1:0]     fcid;
    logic              frv;
    logic              frr;
    logic [NB-1:0]     frid;
    logic [NB-1:0]     crv;
    logic [NB-1:0]     crr;
    logic              busy;
    logic              err;

    // Behavioural model state: lock flag, round-robin pointer, held grant, credits, pending error.
    bit                mLocked;
    int                mRr;
    int                mGnt;
    int                mCnt [NB];
    bit                mErr;

    // Expected outputs and handshake events for the current cycle.
    logic              expIssValid;
    logic [DW-1:0]     expData;
    logic [NB-1:0]     expCoreId;
    logic [NB-1:0]     expCoreReady;
    logic [NB-1:0]     expResValid;
    logic              expResReady;
    logic              expBusy;
    logic              expErr;
    bit                hsIss;
    bit                hsRes;
    bit                errNext;
    int                gIdx;
    int                dIdx;

    int                vectors     = 0;
    int                miscompares = 0;

    always #5 clk_i = ~clk_i;

    fpu_ss_core_arbiter #(
        .NB_CORES        (NB),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .core_issue_valid_i   (civ),
        .core_issue_ready_o   (cir),
        .core_issue_data_i    (cid),
        .fpu_issue_valid_o    (fiv),
        .fpu_issue_ready_i    (fir),
        .fpu_issue_data_o     (fid),
        .fpu_issue_core_id_o  (fcid),
        .fpu_result_valid_i   (frv),
        .fpu_result_ready_o   (frr),
        .fpu_result_core_id_i (frid),
        .core_result_valid_o  (crv),
        .core_result_ready_i  (crr),
        .busy_o               (busy),
        .err_o                (err)
    );

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Work out the expected outputs directly from the arbitration rules.
    task automatic modelEval();
        bit has;
        int g;
        int ones;
        has = 0;
        g   = 0;
        if (mLocked) begin
            has = 1;
            g   = mGnt;
        end else begin
            for (int k = 0; k < NB; k++) begin
                int c;
                c = (mRr + k) % NB;
                if (!has && civ[c] && mCnt[c] < MAXO) begin
                    has = 1;
                    g   = c;
                end
            end
        end
        expIssValid  = has && civ[g];
        expData      = has ? cid[g*DW +: DW] : '0;
        expCoreId    = has ? (NB'(1) << g) : '0;
        expCoreReady = (has && fir) ? (NB'(1) << g) : '0;
        hsIss        = expIssValid && fir;
        gIdx         = g;

        ones = $countones(frid);
        dIdx = 0;
        for (int i = 0; i < NB; i++) begin
            if (frid[i]) dIdx = i;
        end
        expResValid = (frv && ones == 1) ? frid : '0;
        expResReady = (frv && ones != 1) || ((crr & frid) != '0);
        hsRes       = frv && (ones == 1) && crr[dIdx];

        expBusy = 0;
        for (int i = 0; i < NB; i++) begin
            if (mCnt[i] != 0) expBusy = 1;
        end
        expErr  = mErr;
        errNext = (frv && ones != 1) || (hsRes && mCnt[dIdx] == 0 && !(hsIss && gIdx == dIdx));
    endtask

    // Advance the model across one rising edge, using the events modelEval recorded.
    task automatic modelUpdate();
        mErr = errNext;
        if (!(hsIss && hsRes && gIdx == dIdx)) begin
            if (hsIss) mCnt[gIdx]++;
            if (hsRes && mCnt[dIdx] > 0) mCnt[dIdx]--;
        end
        if (hsIss) begin
            mLocked = 0;
            mRr     = (gIdx + 1) % NB;
        end else if (mLocked) begin
            if (!civ[mGnt]) mLocked = 0;
        end else if (expIssValid) begin
            mLocked = 1;
            mGnt    = gIdx;
        end
    endtask

    task automatic modelReset();
        mLocked = 0;
        mRr     = 0;
        mGnt    = 0;
        mErr    = 0;
        for (int i = 0; i < NB; i++) mCnt[i] = 0;
    endtask

    task automatic checkOutput();
        #1;
        modelEval();
        compare("issue_valid", 64'(fiv), 64'(expIssValid));
        compare("issue_data", fid, expData);
        compare("issue_core_id", 64'(fcid), 64'(expCoreId));
        compare("core_issue_ready", 64'(cir), 64'(expCoreReady));
        compare("core_result_valid", 64'(crv), 64'(expResValid));
        compare("result_ready", 64'(frr), 64'(expResReady));
        compare("busy", 64'(busy), 64'(expBusy));
        compare("err", 64'(err), 64'(expErr));
    endtask

    task automatic tick();
        @(posedge clk_i);
        modelUpdate();
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic [NB-1:0] iv, input logic ir, input logic rv,
                                 input logic [NB-1:0] rid, input logic [NB-1:0] rr);
        civ  = iv;
        fir  = ir;
        frv  = rv;
        frid = rid;
        crr  = rr;
    endtask

    task automatic doReset();
        applyStimulus('0, 1'b0, 1'b0, '0, '0);
        rst_ni = 1'b0;
        modelReset();
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput();
        rst_ni = 1'b1;
    endtask

    task automatic applyRandom();
        int r;
        int pick;
        bit found;
        if ($urandom_range(0, 3) == 0) civ = NB'($urandom);
        else civ = civ | (NB'(1) << $urandom_range(0, NB - 1));
        for (int i = 0; i < NB; i++) cid[i*DW +: DW] = {$urandom(), $urandom()};
        fir = ($urandom_range(0, 3) != 0);
        frv = ($urandom_range(0, 2) == 0);
        r   = $urandom_range(0, 9);
        if (r == 0) begin
            frid = NB'($urandom);
        end else begin
            pick  = $urandom_range(0, NB - 1);
            found = 0;
            frid  = NB'(1) << pick;
            for (int k = 0; k < NB; k++) begin
                int c;
                c = (pick + k) % NB;
                if (!found && mCnt[c] > 0) begin
                    found = 1;
                    frid  = NB'(1) << c;
                end
            end
        end
        crr = NB'($urandom) | (($urandom_range(0, 1) == 1) ? frid : '0);
    endtask

    initial begin
        rst_ni = 1'b1;
        cid    = '0;
        applyStimulus('0, 1'b0, 1'b0, '0, '0);
        modelReset();
        @(negedge clk_i);
        doReset();

        // Reset state with idle inputs.
        checkOutput();
        compare("reset_issue_valid", 64'(fiv), 64'd0);
        compare("reset_busy", 64'(busy), 64'd0);
        tick();

        // Round-robin order with every core requesting and the FPU always ready.
        for (int i = 0; i < NB; i++) cid[i*DW +: DW] = 64'hA000_0000_0000_0000 | 64'(i);
        applyStimulus('1, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k <= NB; k++) begin
            checkOutput();
            compare("rr_grant", 64'(fcid), 64'(NB'(1) << (k % NB)));
            compare("rr_ready", 64'(cir), 64'(NB'(1) << (k % NB)));
            tick();
        end

        // Grant lock: core 2 held while the FPU stalls and core 1 joins.
        doReset();
        cid[2*DW +: DW] = 64'hC0DE_0000_0000_0002;
        applyStimulus(8'b0000_0100, 1'b0, 1'b0, '0, '0);
        checkOutput();
        compare("lock_first", 64'(fcid), 64'h04);
        tick();
        applyStimulus(8'b0000_0110, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            checkOutput();
            compare("lock_hold", 64'(fcid), 64'h04);
            compare("lock_data", fid, 64'hC0DE_0000_0000_0002);
            tick();
        end
        fir = 1'b1;
        checkOutput();
        compare("lock_accept", 64'(cir), 64'h04);
        tick();
        applyStimulus(8'b0001_0010, 1'b0, 1'b0, '0, '0);
        checkOutput();
        compare("lock_rr_after", 64'(fcid), 64'h10);
        tick();

        // Credit limit: core 0 stops after MAXO issues and resumes after one result.
        doReset();
        applyStimulus(8'b0000_0001, 1'b1, 1'b0, '0, '0);
        for (int k = 0; k < MAXO; k++) begin
            checkOutput();
            compare("credit_issue", 64'(fcid), 64'h01);
            tick();
        end
        applyStimulus(8'b0000_0001, 1'b1, 1'b1, 8'h01, 8'h01);
        checkOutput();
        compare("credit_blocked_valid", 64'(fiv), 64'd0);
        compare("credit_blocked_ready", 64'(cir), 64'd0);
        compare("credit_result_ready", 64'(frr), 64'd1);
        tick();
        frv = 1'b0;
        checkOutput();
        compare("credit_regain", 64'(fiv), 64'd1);
        compare("credit_regain_id", 64'(fcid), 64'h01);
        tick();

        // Result routing with core 5 back-pressuring.
        doReset();
        applyStimulus(8'h20, 1'b1, 1'b0, '0, '0);
        checkOutput();
        tick();
        applyStimulus('0, 1'b0, 1'b1, 8'b0010_0000, '0);
        for (int k = 0; k < 2; k++) begin
            checkOutput();
            compare("route_valid", 64'(crv), 64'h20);
            compare("route_stall", 64'(frr), 64'd0);
            compare("route_busy", 64'(busy), 64'd1);
            tick();
        end
        crr = 8'h20;
        checkOutput();
        compare("route_accept", 64'(frr), 64'd1);
        tick();
        frv = 1'b0;
        checkOutput();
        compare("route_drained", 64'(busy), 64'd0);
        tick();

        // Malformed result IDs, and a result for a core with nothing in flight.
        applyStimulus('0, 1'b0, 1'b1, 8'b0000_0011, '1);
        checkOutput();
        compare("bad_id_ready", 64'(frr), 64'd1);
        compare("bad_id_no_valid", 64'(crv), 64'd0);
        tick();
        frv = 1'b0;
        checkOutput();
        compare("bad_id_err", 64'(err), 64'd1);
        tick();
        checkOutput();
        compare("bad_id_err_clear", 64'(err), 64'd0);
        tick();
        applyStimulus('0, 1'b0, 1'b1, 8'h40, '1);
        checkOutput();
        tick();
        frv = 1'b0;
        checkOutput();
        compare("zero_cnt_err", 64'(err), 64'd1);
        compare("zero_cnt_busy", 64'(busy), 64'd0);
        tick();

        // Issue and result on core 3 in the same cycle leave its count unchanged.
        doReset();
        applyStimulus(8'h08, 1'b1, 1'b0, '0, '0);
        checkOutput();
        tick();
        applyStimulus(8'h08, 1'b1, 1'b1, 8'h08, 8'h08);
        checkOutput();
        compare("simul_issue", 64'(cir), 64'h08);
        compare("simul_result", 64'(crv), 64'h08);
        tick();
        applyStimulus('0, 1'b0, 1'b0, '0, '0);
        checkOutput();
        compare("simul_busy", 64'(busy), 64'd1);
        tick();
        applyStimulus('0, 1'b0, 1'b1, 8'h08, 8'h08);
        checkOutput();
        tick();
        frv = 1'b0;
        checkOutput();
        compare("simul_drained", 64'(busy), 64'd0);
        tick();

        // Reset while a grant is locked discards the grant and all credits.
        applyStimulus(8'h20, 1'b1, 1'b0, '0, '0);
        checkOutput();
        tick();
        applyStimulus(8'h04, 1'b0, 1'b0, '0, '0);
        checkOutput();
        tick();
        checkOutput();
        compare("prereset_locked", 64'(fcid), 64'h04);
        doReset();
        applyStimulus('1, 1'b1, 1'b0, '0, '0);
        checkOutput();
        compare("postreset_grant", 64'(fcid), 64'h01);
        compare("postreset_busy", 64'(busy), 64'd0);
        tick();

        // Randomized traffic against the model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) doReset();
            applyRandom();
            checkOutput();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_ss_core_arbiter.md
# fpu_ss_core_arbiter

Shares one FPU subsystem issue/result port pair between `NB_CORES` cluster cores. Issue requests are arbitrated round-robin, and the grant is locked until the issue handshake completes. Each result is routed back to the originating core using a one-hot core ID, and per-core outstanding counters stop any single core from exceeding `MAX_OUTSTANDING` in-flight instructions. The block sits between the cores' offload ports and the FPU subsystem issue/result interface, upstream of the subsystem controller.

## Interface
Parameters:
- `NB_CORES`, 8: number of requesting cores (≥2).
- `DATA_WIDTH`, 64: opaque issue payload width (instr, operands, id).
- `MAX_OUTSTANDING`, 4: per-core in-flight limit (≥1).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `core_issue_valid_i`  in  NB_CORES  per-core issue request.
- `core_issue_ready_o`  out  NB_CORES  per-core issue accept.
- `core_issue_data_i`  in  NB_CORES×DATA_WIDTH  per-core payload.
- `fpu_issue_valid_o`  out  1  request toward the FPU subsystem.
- `fpu_issue_ready_i`  in  1  FPU subsystem accept.
- `fpu_issue_data_o`  out  DATA_WIDTH  payload of the granted core.
- `fpu_issue_core_id_o`  out  NB_CORES  one-hot granted core.
- `fpu_result_valid_i`  in  1  result from the FPU subsystem.
- `fpu_result_ready_o`  out  1  result accept.
- `fpu_result_core_id_i`  in  NB_CORES  one-hot destination core.
- `core_result_valid_o`  out  NB_CORES  per-core result valid.
- `core_result_ready_i`  in  NB_CORES  per-core result ready.
- `busy_o`  out  1  any counter non-zero.
- `err_o`  out  1  one-cycle pulse on a malformed result ID.

## Operation
**Eligibility**
- Core i is eligible when `core_issue_valid_i[i]` is high and `cnt_q[i] < MAX_OUTSTANDING`.

**Arbitration state machine (`IDLE`, `LOCKED`)**
- `IDLE`:
  - The picker selects the first eligible core at index ≥ `rr_q`, wrapping at `NB_CORES`.
  - If no core is eligible, `fpu_issue_valid_o` is 0.
- `LOCKED`:
  - The grant is the stored index `gnt_q`.
  - New requests and eligibility changes are ignored until the handshake completes.
- Grant without handshake in `IDLE` → `LOCKED`, storing `gnt_q`.
- Handshake in either state → `IDLE`, with `rr_q <= gnt + 1` (wrapping `NB_CORES-1` → 0).

**Issue datapath**
- `fpu_issue_valid_o = core_issue_valid_i[gnt]` whenever a grant exists.
- `fpu_issue_data_o` carries the granted core's payload.
- `fpu_issue_core_id_o = 1 << gnt`.
- `core_issue_ready_o[gnt] = fpu_issue_ready_i`; all other bits are 0.
- A core in `LOCKED` must not deassert valid. If it does, the FSM returns to `IDLE` with `rr_q` unchanged.

**Counters**
- Width is `$clog2(MAX_OUTSTANDING+1)`.
- An issue handshake increments `cnt[gnt]`.
- A result handshake decrements `cnt[dest]`.
- Both on the same core in the same cycle leave the count unchanged.
- Counters never wrap: a decrement at 0 is suppressed and pulses `err_o`.

**Result routing**
- `core_result_valid_o[i] = fpu_result_valid_i & fpu_result_core_id_i[i]`.
- `fpu_result_ready_o = |(core_result_ready_i & fpu_result_core_id_i)`.
- If `fpu_result_core_id_i` is zero or multi-hot while valid:
  - `fpu_result_ready_o = 1` and the result is dropped.
  - No `core_result_valid_o` bit is raised.
  - `err_o` pulses for one cycle.

**Status**
- `busy_o = |cnt_q`.

## Timing
- Arbitration, issue and result paths are combinational: zero-cycle grant and zero-cycle result routing. State updates on the rising `clk_i` edge.
- Reset values: state `IDLE`, `rr_q=0`, `gnt_q=0`, all `cnt_q=0`, `err_o` register 0.
- With inputs idle after reset, all outputs are 0.
- Reset mid-operation discards any locked grant and all counters.
- Fairness: a continuously eligible core is granted within `NB_CORES` handshakes.
- A core at `MAX_OUTSTANDING` regains eligibility in the cycle after its result handshake.
- Simultaneous issue to core A and result to core B are independent; both counters update in the same edge.

## Structure
- `fpu_ss_pkg` additions:
  - `arb_state_e` enum: `IDLE`, `LOCKED`.
  - `onehot_valid` helper function, returning true when a vector is exactly one-hot.
- Sub-module `fpu_ss_rr_pick`:
  - Parameter `N`.
  - Inputs: request vector, start pointer.
  - Outputs: `found`, index.
  - Purely combinational; reused for the eligibility search.
- Counters and the FSM live in `fpu_ss_core_arbiter`.

## Test plan
1. **Round-robin order.** All 8 cores valid, `fpu_issue_ready_i=1` constantly → grants 0,1,…,7,0 on consecutive cycles; each core's `core_issue_ready_o` high exactly once per 8 cycles.
2. **Grant lock.** Core 2 granted, `fpu_issue_ready_i=0` for 3 cycles while core 1 also raises valid → grant stays 2 and `fpu_issue_data_o` is stable; on ready, core 2 is accepted and `rr_q` becomes 3.
3. **Credit limit.**
   - `MAX_OUTSTANDING=4`, core 0 issues 4 with no results → 5th request is not granted and `core_issue_ready_o[0]=0`.
   - One result to core 0 → the next cycle core 0 is granted again.
4. **Result routing.** `fpu_result_core_id_i=8'b0010_0000`, `core_result_ready_i[5]=0` for 2 cycles → `core_result_valid_o[5]=1` and `fpu_result_ready_o=0`; when ready, counter 5 decrements by 1.
5. **Malformed result ID.**
   - `fpu_result_core_id_i=8'b0000_0011` with valid → `fpu_result_ready_o=1`, no core valid, `err_o` pulses for 1 cycle.
   - Result to a core with `cnt=0` → `err_o` pulses and the counter stays 0.
6. **Simultaneous events and reset.**
   - Issue and result on core 3 in the same cycle → `cnt[3]` unchanged.
   - `rst_ni` asserted while in `LOCKED` → `IDLE`, `busy_o=0`, first grant after release goes to core 0.
